// File: rtl/delay_15_ctrl.sv
// Configuration sequencer for the delay_15 variable delay line.
// Accepts delay-change requests, holds the line in reset for a flush window,
// counts refill cycles, then flags the line output as valid.
module delay_15_ctrl #(
    parameter int unsigned DELAY_W      = 4,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [DELAY_W-1:0] cfg_delay_i,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    output logic               delay_rst_o,
    output logic [DELAY_W-1:0] data_delay_o,
    output logic               out_valid_o,
    output logic               cfg_done_o
);

    typedef enum logic [1:0] {StIdle, StFlush, StFill, StRun} state_e;

    // FLUSH_CYCLES is limited to 1..15, so four bits always hold the reload value.
    localparam int unsigned FlushW = 4;
    localparam logic [FlushW-1:0] FlushLoad = FlushW'(FLUSH_CYCLES - 1);

    state_e             state_q, state_d;
    logic [FlushW-1:0]  flush_cnt_q, flush_cnt_d;
    logic [DELAY_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic               dl_rst_q, dl_rst_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;

    logic               accept;
    logic [DELAY_W-1:0] fill_last;

    assign accept    = cfg_valid_i && ready_q;
    // Never evaluated with delay_q == 0 (FILL is skipped), so no wrap occurs.
    assign fill_last = delay_q - DELAY_W'(1);

    // Next-state, counters and registered-output precomputation.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        fill_cnt_d  = fill_cnt_q;
        delay_d     = delay_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    delay_d     = cfg_delay_i;
                    flush_cnt_d = FlushLoad;
                    state_d     = StFlush;
                end
            end
            StFlush: begin
                if (flush_cnt_q == '0) begin
                    fill_cnt_d = '0;
                    state_d    = (delay_q == '0) ? StRun : StFill;
                end else begin
                    flush_cnt_d = flush_cnt_q - FlushW'(1);
                end
            end
            StFill: begin
                if (fill_cnt_q == fill_last) begin
                    state_d = StRun;
                end else begin
                    fill_cnt_d = fill_cnt_q + DELAY_W'(1);
                end
            end
            StRun: begin
                // A request for the delay already active is acknowledged without effect.
                if (accept && (cfg_delay_i != delay_q)) begin
                    delay_d     = cfg_delay_i;
                    flush_cnt_d = FlushLoad;
                    state_d     = StFlush;
                end
            end
        endcase

        dl_rst_d = (state_d == StIdle) || (state_d == StFlush);
        valid_d  = (state_d == StRun);
        ready_d  = (state_d == StIdle) || (state_d == StRun);
        done_d   = (state_d == StRun) && (state_q != StRun);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            flush_cnt_q <= '0;
            fill_cnt_q  <= '0;
            delay_q     <= '0;
            dl_rst_q    <= 1'b1;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            fill_cnt_q  <= fill_cnt_d;
            delay_q     <= delay_d;
            dl_rst_q    <= dl_rst_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    assign cfg_ready_o  = ready_q;
    assign delay_rst_o  = dl_rst_q;
    assign data_delay_o = delay_q;
    assign out_valid_o  = valid_q;
    assign cfg_done_o   = done_q;

endmodule

// File: tb/tb_delay_15_ctrl.sv
// Bench for delay_15_ctrl: two instances (flush window 1 and 4) share one stimulus
// stream; a cycle-count reference model predicts every output each cycle.
module tb_delay_15_ctrl;

    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_delay = '0;

    logic [1:0]   ready_w, drst_w, oval_w, done_w;
    logic [W-1:0] dd0, dd1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycles elapsed since the last accepted (non no-op) request.
    int           fl [2];
    bit           cfgd [2];
    int           k [2];
    logic [W-1:0] cur [2];
    bit           last_acc [2];

    delay_15_ctrl #(.DELAY_W(W), .FLUSH_CYCLES(1)) u_dut1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_delay_i (cfg_delay),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (ready_w[0]),
        .delay_rst_o (drst_w[0]),
        .data_delay_o(dd0),
        .out_valid_o (oval_w[0]),
        .cfg_done_o  (done_w[0])
    );

    delay_15_ctrl #(.DELAY_W(W), .FLUSH_CYCLES(4)) u_dut4 (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_delay_i (cfg_delay),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (ready_w[1]),
        .delay_rst_o (drst_w[1]),
        .data_delay_o(dd1),
        .out_valid_o (oval_w[1]),
        .cfg_done_o  (done_w[1])
    );

    function automatic bit m_run(input int i);
        return cfgd[i] && (k[i] > fl[i] + int'(cur[i]));
    endfunction

    function automatic bit m_ready(input int i);
        return !cfgd[i] || m_run(i);
    endfunction

    function automatic bit m_rst(input int i);
        return !cfgd[i] || (k[i] <= fl[i]);
    endfunction

    function automatic bit m_done(input int i);
        return cfgd[i] && (k[i] == fl[i] + 1 + int'(cur[i]));
    endfunction

    task automatic chk(input string tag, input int i, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s inst=F%0d observed=%0d expected=%0d", tag, fl[i], obs, exp);
        end
    endtask

    task automatic step();
        bit acc;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            acc = cfg_valid && m_ready(i) && !rst;
            last_acc[i] = acc;
            if (rst) begin
                cfgd[i] = 1'b0;
                cur[i]  = '0;
                k[i]    = 0;
            end else if (acc && !(m_run(i) && (cfg_delay == cur[i]))) begin
                cfgd[i] = 1'b1;
                cur[i]  = cfg_delay;
                k[i]    = 1;
            end else if (cfgd[i] && k[i] < 10000) begin
                k[i]++;
            end
        end
        #1;
        chk("delay_rst", 0, int'(drst_w[0]), int'(m_rst(0)));
        chk("out_valid", 0, int'(oval_w[0]), int'(m_run(0)));
        chk("cfg_ready", 0, int'(ready_w[0]), int'(m_ready(0)));
        chk("cfg_done", 0, int'(done_w[0]), int'(m_done(0)));
        chk("data_delay", 0, int'(dd0), int'(cur[0]));
        chk("delay_rst", 1, int'(drst_w[1]), int'(m_rst(1)));
        chk("out_valid", 1, int'(oval_w[1]), int'(m_run(1)));
        chk("cfg_ready", 1, int'(ready_w[1]), int'(m_ready(1)));
        chk("cfg_done", 1, int'(done_w[1]), int'(m_done(1)));
        chk("data_delay", 1, int'(dd1), int'(cur[1]));
    endtask

    // Hold a request until the F=1 instance accepts it.
    task automatic request(input logic [W-1:0] d);
        int n;
        n = 0;
        cfg_valid = 1'b1;
        cfg_delay = d;
        do begin
            step();
            n++;
        end while (!last_acc[0] && n < 100);
        cfg_valid = 1'b0;
        n_checks++;
        assert (last_acc[0])
        else begin
            n_fail++;
            $error("FAIL accept_timeout observed=0 expected=1");
        end
    endtask

    // Called in cycle T+1 after an accept; checks the cycle at which out_valid rises.
    task automatic rise(input int exp);
        int n;
        n = 1;
        while (!oval_w[0] && n < 60) begin
            step();
            n++;
        end
        chk("rise_cycle", 0, n, exp);
    endtask

    initial begin
        fl[0] = 1;
        fl[1] = 4;
        for (int i = 0; i < 2; i++) begin
            cfgd[i] = 1'b0;
            k[i] = 0;
            cur[i] = '0;
            last_acc[i] = 1'b0;
        end

        // Reset state
        rst = 1'b1;
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            chk("reset_rst", i, int'(drst_w[i]), 1);
            chk("reset_ready", i, int'(ready_w[i]), 1);
            chk("reset_valid", i, int'(oval_w[i]), 0);
        end
        rst = 1'b0;
        step();

        // D=5 from IDLE; both instances accept on the same edge
        request(4'd5);
        chk("d5_rst_t1", 0, int'(drst_w[0]), 1);
        rise(7);
        repeat (32) step();

        // D=0: straight from FLUSH to RUN
        request(4'd0);
        rise(2);
        repeat (3) step();

        // D=15, then the same delay again is a no-op in RUN
        request(4'd15);
        rise(17);
        repeat (2) step();
        request(4'd15);
        chk("noop_valid", 0, int'(oval_w[0]), 1);
        chk("noop_done", 0, int'(done_w[0]), 0);
        chk("noop_rst", 0, int'(drst_w[0]), 0);
        repeat (5) step();

        // RUN with D=3, then D=12; a request held during FILL waits for RUN
        request(4'd3);
        rise(5);
        repeat (2) step();
        request(4'd12);
        chk("reconf_drop", 0, int'(oval_w[0]), 0);
        cfg_valid = 1'b1;
        cfg_delay = 4'd7;
        rise(14);
        request(4'd7);
        rise(9);
        repeat (2) step();

        // Reset in the middle of FILL for D=10
        request(4'd10);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_rst", 0, int'(drst_w[0]), 1);
        chk("abort_valid", 0, int'(oval_w[0]), 0);
        chk("abort_ready", 0, int'(ready_w[0]), 1);
        chk("abort_delay", 0, int'(dd0), 0);
        chk("abort_done", 0, int'(done_w[0]), 0);
        repeat (15) step();

        // Flush window of 4 with D=2, both instances idle so both accept
        request(4'd2);
        for (int n = 1; n <= 8; n++) begin
            chk("f4_delay_rst", 1, int'(drst_w[1]), int'(n <= 4));
            chk("f4_out_valid", 1, int'(oval_w[1]), int'(n >= 7));
            step();
        end

        // Random traffic, biased toward repeats of the active delay and rare resets
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 59) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) cfg_delay = cur[0];
            else cfg_delay = W'($urandom);
            step();
        end
        rst = 1'b0;
        cfg_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
